// File: rtl/md_unit.sv
// md_unit: MIPS E-stage multiply/divide unit holding HI/LO with multi-cycle busy/stall handshake
module md_unit #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_req,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic div0;
  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic sgn, na, nb;
  logic [WIDTH-1:0] am, bm, uq, ur, q, r;
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sgn = ~md_op[0];
    na = sgn & a[WIDTH-1];
    nb = sgn & b[WIDTH-1];
    am = na ? -a : a;
    // divisor forced nonzero so b==0 yields defined values; div0 suppresses the commit anyway
    bm = b == '0 ? WIDTH'(1) : (nb ? -b : b);
    uq = am / bm;
    ur = am % bm;
    q = (na ^ nb) ? -uq : uq;
    r = na ? -ur : ur;
    res = md_op[1] ? {r, q} : (md_op[0] ? prod_u : prod_s);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (state == IDLE) begin
      if (start && !md_op[2]) begin
        res_hi <= res[2*WIDTH-1:WIDTH];
        res_lo <= res[WIDTH-1:0];
        div0 <= md_op[1] && b == '0;
        cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state <= RUN;
      end else if (start && md_op == 3'b100) hi <= a;
      else if (start && md_op == 3'b101) lo <= a;
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        if (!div0) begin
          hi <= res_hi;
          lo <= res_lo;
        end
        div0 <= 1'b0;
        state <= IDLE;
      end
    end
  end
  assign busy = state == RUN;
  assign stall = md_req & (busy | (start & ~md_op[2]));
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against a 64-bit arithmetic reference model
module tb_md_unit;
  logic clk = 0, reset = 0, start = 0, md_req = 0;
  logic [2:0] md_op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, stall;
  logic [31:0] hi, lo;
  logic [31:0] exp_hi = 0, exp_lo = 0;
  int tests = 0, fails = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .md_req(md_req), .busy(busy), .stall(stall), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, y, input logic [63:0] cur);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: return y == 0 ? cur : {32'(sx % sy), 32'(sx / sy)};
      3'd3: return y == 0 ? cur : {32'(ux % uy), 32'(ux / uy)};
      3'd4: return {x, cur[31:0]};
      3'd5: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op);
    return op[2] ? 0 : (op[1] ? 10 : 5);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] x, y, output logic st, output int cyc);
    start = 1; md_op = op; a = x; b = y; md_req = 1;
    #1 st = stall;
    tick();
    start = 0; md_req = 0;
    {exp_hi, exp_lo} = ref_md(op, x, y, {exp_hi, exp_lo});
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 0; md_req = 1; start = 1; md_op = 3'b000;
    tick(); tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall_mult got %b want 1", stall); end
    md_op = 3'b100; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_mthi got %b want 0", stall); end
    start = 0; md_req = 0; reset = 1;
    tick();
  endtask

  task automatic test_plan;
    logic st;
    int cyc;
    issue(3'd0, 32'hFFFFFFFD, 32'd5, st, cyc);
    tests++; if (cyc !== 5) begin fails++; $display("FAIL mult_busy got %0d want 5", cyc); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL mult_res got %h/%h want ffffffff/fffffff1", hi, lo); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2, st, cyc);
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL multu_stall got %b want 1", st); end
    tests++; if (cyc !== 5 || hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_res got %0d %h/%h want 5 00000001/fffffffe", cyc, hi, lo); end
    md_req = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_release got %b want 0", stall); end
    md_req = 0;
    issue(3'd2, 32'hFFFFFFF9, 32'd2, st, cyc);
    tests++; if (cyc !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_res got %0d %h/%h want 10 ffffffff/fffffffd", cyc, hi, lo); end
    issue(3'd3, 32'd7, 32'd2, st, cyc);
    tests++; if (hi !== 32'd1 || lo !== 32'd3) begin fails++; $display("FAIL divu_res got %h/%h want 1/3", hi, lo); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, st, cyc);
    tests++; if (hi !== 32'd0 || lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf got %h/%h want 0/80000000", hi, lo); end
  endtask

  task automatic test_mt_div0;
    logic st;
    int cyc;
    issue(3'd4, 32'h1234, 32'd0, st, cyc);
    tests++; if (hi !== 32'h1234 || cyc !== 0 || st !== 1'b0) begin fails++; $display("FAIL mthi got %h cyc %0d st %b want 1234 0 0", hi, cyc, st); end
    issue(3'd5, 32'h5678, 32'd0, st, cyc);
    tests++; if (lo !== 32'h5678 || cyc !== 0) begin fails++; $display("FAIL mtlo got %h cyc %0d want 5678 0", lo, cyc); end
    issue(3'd3, 32'd99, 32'd0, st, cyc);
    tests++; if (cyc !== 10 || hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL divu0 got %0d %h/%h want 10 1234/5678", cyc, hi, lo); end
    issue(3'd2, 32'hFFFFFF00, 32'd0, st, cyc);
    tests++; if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL div0 got %h/%h want 1234/5678", hi, lo); end
    issue(3'd6, 32'hDEAD, 32'hBEEF, st, cyc);
    tests++; if (cyc !== 0 || hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL noop got %0d %h/%h want 0 1234/5678", cyc, hi, lo); end
  endtask

  task automatic test_ignored_start;
    int cyc;
    start = 1; md_op = 3'd0; a = 32'd1000; b = 32'hFFFFFFF0;
    tick();
    start = 0;
    {exp_hi, exp_lo} = ref_md(3'd0, 32'd1000, 32'hFFFFFFF0, {exp_hi, exp_lo});
    tick();
    cyc = 1;
    start = 1; md_op = 3'd5; a = 32'hAAAA;
    tick();
    cyc++;
    start = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    tests++; if (cyc !== 5) begin fails++; $display("FAIL ignored_busy got %0d want 5", cyc); end
    tests++; if (hi !== exp_hi || lo !== exp_lo) begin fails++; $display("FAIL ignored_res got %h/%h want %h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_abort;
    start = 1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    tick();
    start = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    reset = 1;
    exp_hi = 0; exp_lo = 0;
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL abort got %b %h/%h want 0 0/0", busy, hi, lo); end
    repeat (12) tick();
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL abort_late got %b %h/%h want 0 0/0", busy, hi, lo); end
  endtask

  task automatic test_back_to_back;
    logic st;
    int cyc;
    logic [2:0] op;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x = (i % 5 == 0) ? 32'h80000000 : $urandom;
      y = (i % 7 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      issue(op, x, y, st, cyc);
      tests++; if (st !== ~op[2]) begin fails++; $display("FAIL rnd_stall op %0d got %b want %b", op, st, ~op[2]); end
      tests++; if (cyc !== lat(op)) begin fails++; $display("FAIL rnd_busy op %0d got %0d want %0d", op, cyc, lat(op)); end
      tests++; if (hi !== exp_hi || lo !== exp_lo) begin fails++; $display("FAIL rnd_res op %0d a %h b %h got %h/%h want %h/%h", op, x, y, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_mt_div0();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
